// File: rtl/cpu_state_snapshot_if.sv
// Snapshot beat stream: payload, beat tag, last marker and valid/ready handshake.
interface cpu_state_snapshot_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic [2:0]        tag;
    logic              last;
    logic              valid;
    logic              ready;

    modport master (output data, tag, last, valid, input ready);
    modport slave  (input data, tag, last, valid, output ready);
endinterface

// File: rtl/cpu_state_snapshot.sv
// Counts CPU cycles, periodically stalls the core and streams HDR/PC/REG/MEM beats.
// Define SNAP_CHECKSUM_EN to append an XOR checksum beat (tag 4) after the memory beats.
module cpu_state_snapshot #(
    parameter int DATA_W      = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_WORDS   = 8,
    parameter int MEM_AW      = 3,
    parameter int CNT_W       = 16,
    parameter int PERIOD      = 1,
    parameter int CYCLE_LIMIT = 30
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  trig_i,
    input  logic [DATA_W-1:0]     pc_i,
    output logic [REG_AW-1:0]     reg_addr_o,
    input  logic [DATA_W-1:0]     reg_data_i,
    output logic [MEM_AW-1:0]     mem_addr_o,
    input  logic [DATA_W-1:0]     mem_data_i,
    output logic                  cpu_stall_o,
    cpu_state_snapshot_if.master  dout,
    output logic [CNT_W-1:0]      cycle_cnt_o,
    output logic                  done_o
);

    localparam int IW = (REG_AW > MEM_AW) ? REG_AW : MEM_AW;
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PC,
        S_REG,
        S_MEM,
`ifdef SNAP_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t            state;
    state_t            beat_nxt;
    state_t            end_state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nxt;
    logic [CNT_W-1:0]  cyc;
    logic [CNT_W-1:0]  cyc_inc;
    logic [PW-1:0]     pcnt;
    logic              period_wrap;
    logic              limit_hit;
    logic              snap_req;
    logic              stall;
    logic              valid;
    logic              done;
    logic [2:0]        tag;
    logic              last;
    logic              last_nxt;
    logic [DATA_W-1:0] beat_data;
`ifdef SNAP_CHECKSUM_EN
    logic [DATA_W-1:0] chk;
`endif

    function automatic logic [2:0] tag_of(input state_t s);
        case (s)
            S_PC:    tag_of = 3'd1;
            S_REG:   tag_of = 3'd2;
            S_MEM:   tag_of = 3'd3;
`ifdef SNAP_CHECKSUM_EN
            S_CHK:   tag_of = 3'd4;
`endif
            default: tag_of = 3'd0;
        endcase
    endfunction

    assign cyc_inc     = cyc + 1'b1;
    assign period_wrap = (pcnt == PW'(PERIOD - 1));
    assign limit_hit   = (CYCLE_LIMIT != 0) && (cyc_inc == CNT_W'(CYCLE_LIMIT));
    assign snap_req    = trig_i || (start_i && (period_wrap || limit_hit));
    assign end_state   = ((CYCLE_LIMIT != 0) && (cyc == CNT_W'(CYCLE_LIMIT))) ? S_DONE : S_IDLE;

    // Successor beat; only consumed when the current beat is accepted.
    always_comb begin
        beat_nxt = state;
        idx_nxt  = idx;
        case (state)
            S_HDR: beat_nxt = S_PC;
            S_PC: begin
                beat_nxt = S_REG;
                idx_nxt  = '0;
            end
            S_REG: begin
                if (idx == IW'(REG_NUM - 1)) begin
                    beat_nxt = S_MEM;
                    idx_nxt  = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            S_MEM: begin
                if (idx == IW'(MEM_WORDS - 1)) begin
`ifdef SNAP_CHECKSUM_EN
                    beat_nxt = S_CHK;
`else
                    beat_nxt = end_state;
`endif
                    idx_nxt  = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
`ifdef SNAP_CHECKSUM_EN
            S_CHK: beat_nxt = end_state;
`endif
            default: beat_nxt = state;
        endcase
`ifdef SNAP_CHECKSUM_EN
        last_nxt = (beat_nxt == S_CHK);
`else
        last_nxt = (beat_nxt == S_MEM) && (idx_nxt == IW'(MEM_WORDS - 1));
`endif
    end

    always_comb begin
        beat_data = '0;
        case (state)
            S_HDR:   beat_data = DATA_W'(cyc);
            S_PC:    beat_data = pc_i;
            S_REG:   beat_data = reg_data_i;
            S_MEM:   beat_data = mem_data_i;
`ifdef SNAP_CHECKSUM_EN
            S_CHK:   beat_data = chk;
`endif
            default: beat_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            idx   <= '0;
            cyc   <= '0;
            pcnt  <= '0;
            stall <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b0;
            tag   <= '0;
            last  <= 1'b0;
`ifdef SNAP_CHECKSUM_EN
            chk   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        cyc  <= cyc_inc;
                        pcnt <= period_wrap ? '0 : pcnt + 1'b1;
                    end
                    if (snap_req) begin
                        state <= S_HDR;
                        idx   <= '0;
                        stall <= 1'b1;
                        valid <= 1'b1;
                        tag   <= tag_of(S_HDR);
                        last  <= 1'b0;
`ifdef SNAP_CHECKSUM_EN
                        chk   <= '0;
`endif
                    end
                end
                S_DONE: done <= 1'b1;
                default: begin
                    if (valid && dout.ready) begin
`ifdef SNAP_CHECKSUM_EN
                        chk   <= chk ^ beat_data;
`endif
                        state <= beat_nxt;
                        idx   <= idx_nxt;
                        if (beat_nxt == S_IDLE || beat_nxt == S_DONE) begin
                            valid <= 1'b0;
                            stall <= (beat_nxt == S_DONE);
                            done  <= (beat_nxt == S_DONE);
                            tag   <= '0;
                            last  <= 1'b0;
                        end else begin
                            tag  <= tag_of(beat_nxt);
                            last <= last_nxt;
                        end
                    end
                end
            endcase
        end
    end

    assign reg_addr_o  = (state == S_REG) ? idx[REG_AW-1:0] : '0;
    assign mem_addr_o  = (state == S_MEM) ? idx[MEM_AW-1:0] : '0;
    assign dout.data   = beat_data;
    assign dout.tag    = tag;
    assign dout.last   = last;
    assign dout.valid  = valid;
    assign cpu_stall_o = stall;
    assign cycle_cnt_o = cyc;
    assign done_o      = done;

endmodule
